mc_result_serializer: RTL and testbench

- Output-side counterpart of the serial-to-parallel input path of the motion-compensation IC.
- Accepts parallel result words from the calc stage through a valid/ready handshake and buffers them in a small FIFO.
- Shifts each word out MSB-first on a single serial pin, with framing strobes marking each FRAME_LEN-word result block (default 9 = 3x3 window).

---
 rtl/mc_result_serializer.sv | 164 ++++++++++++++++
 tb/tb_mc_result_serializer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_result_serializer.sv
// Buffers parallel result words in a small FIFO and shifts them out MSB-first with frame strobes.
// Optional MC_TX_PARITY_EN appends an even-parity bit after the LSB of every word.
module mc_result_serializer #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned FRAME_LEN  = 9
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          sout,
  output logic                          sout_valid,
  output logic                          sof,
  output logic                          eof,
  output logic                          frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned BW = $clog2(DATA_W);
  localparam int unsigned WW = 8;

`ifdef MC_TX_PARITY_EN
  typedef enum logic [1:0] {StIdle, StShift, StPar} state_e;
  logic par_q, par_d;
`else
  typedef enum logic [0:0] {StIdle, StShift} state_e;
`endif

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     level_q, level_d;
  logic [DATA_W-1:0] shift_q, shift_d, head;
  logic [BW-1:0]     bit_q, bit_d;
  logic [WW-1:0]     word_q, word_d;
  logic              push, pop, fifo_empty, word_end;
  logic              sout_d, valid_d, sof_d, eof_d;

  assign in_ready   = (level_q != LW'(FIFO_DEPTH));
  assign fifo_level = level_q;
  assign fifo_empty = (level_q == '0);
  assign push       = in_valid & in_ready;
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    word_d   = word_q;
    pop      = 1'b0;
    word_end = 1'b0;
`ifdef MC_TX_PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      StShift: begin
        shift_d = shift_q << 1;
        bit_d   = bit_q + 1'b1;
        if (bit_q == BW'(DATA_W - 1)) begin
`ifdef MC_TX_PARITY_EN
          state_d = StPar;
          bit_d   = '0;
`else
          word_end = 1'b1;
`endif
        end
      end
`ifdef MC_TX_PARITY_EN
      StPar: word_end = 1'b1;
`endif
      default: ;
    endcase

    // Underrun keeps the word counter, so the frame resumes with the next word.
    if (word_end) begin
      word_d  = (word_q == WW'(FRAME_LEN - 1)) ? '0 : word_q + 1'b1;
      state_d = StIdle;
      bit_d   = '0;
    end
    if (((state_q == StIdle) || word_end) && !fifo_empty) begin
      pop     = 1'b1;
      state_d = StShift;
      shift_d = head;
      bit_d   = '0;
`ifdef MC_TX_PARITY_EN
      par_d   = ^head;
`endif
    end

    // Outputs are decoded from next state so every pin leaves a flop.
    sout_d  = 1'b0;
    valid_d = 1'b0;
    sof_d   = 1'b0;
    eof_d   = 1'b0;
    if (state_d == StShift) begin
      valid_d = 1'b1;
      sout_d  = shift_d[DATA_W-1];
      sof_d   = (bit_d == '0) && (word_d == '0);
`ifndef MC_TX_PARITY_EN
      eof_d   = (bit_d == BW'(DATA_W - 1)) && (word_d == WW'(FRAME_LEN - 1));
`endif
    end
`ifdef MC_TX_PARITY_EN
    if (state_d == StPar) begin
      valid_d = 1'b1;
      sout_d  = par_d;
      eof_d   = (word_d == WW'(FRAME_LEN - 1));
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      shift_q    <= '0;
      bit_q      <= '0;
      word_q     <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      sof        <= 1'b0;
      eof        <= 1'b0;
      frame_done <= 1'b0;
`ifdef MC_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q    <= level_d;
      shift_q    <= shift_d;
      bit_q      <= bit_d;
      word_q     <= word_d;
      sout       <= sout_d;
      sout_valid <= valid_d;
      sof        <= sof_d;
      eof        <= eof_d;
      frame_done <= eof;
`ifdef MC_TX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_mc_result_serializer.sv
// Bench for mc_result_serializer: table vectors for single words plus a bit-level scoreboard.
module tb_mc_result_serializer;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned FL    = 9;
`ifdef MC_TX_PARITY_EN
  localparam int unsigned PAR = 1;
`else
  localparam int unsigned PAR = 0;
`endif
  localparam int unsigned PER = DW + PAR;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready, sout, sout_valid, sof, eof, frame_done;
  logic [2:0]    fifo_level;

  mc_result_serializer #(
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH),
    .FRAME_LEN  (FL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .sof        (sof),
    .eof        (eof),
    .frame_done (frame_done),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic b;
    logic first;
    logic sof;
    logic eof;
  } exp_bit_t;

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_bits;
    logic       exp_par;
  } vec_t;

  exp_bit_t exp_q[$];
  exp_bit_t mon_e;
  vec_t     vecs[6];
  int       n_cmp = 0, n_fail = 0;
  int       mw = 0, acc_cnt = 0, started = 0, model_lvl;
  int       cyc = 0, nvalid, nsof, nfd, first_v, last_v;
  bit       saw_full, mon_en = 1'b0;
  logic     prev_eof = 1'b0, fd_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic enqueue(input logic [DW-1:0] d);
    for (int i = 0; i < int'(PER); i++) begin
      exp_bit_t e;
      e.b     = (i < int'(DW)) ? d[DW-1-i] : ^d;
      e.first = (i == 0);
      e.sof   = (mw == 0) && (i == 0);
      e.eof   = (mw == int'(FL) - 1) && (i == int'(PER) - 1);
      exp_q.push_back(e);
    end
    mw = (mw == int'(FL) - 1) ? 0 : mw + 1;
  endtask

  task automatic clear_stats();
    nvalid = 0; nsof = 0; nfd = 0; first_v = -1; last_v = -1; saw_full = 1'b0;
  endtask

  // Monitor: every bit on sout is checked against the scoreboard; FIFO level is modelled.
  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      fd_exp = prev_eof;
      if (sout_valid) begin
        nvalid++;
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
        if (sof) nsof++;
        if (exp_q.size() == 0) begin
          check("unexpected_bit", 1, 0);
          prev_eof = 1'b0;
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.first) started++;
          check("sout", sout, mon_e.b);
          check("sof", sof, mon_e.sof);
          check("eof", eof, mon_e.eof);
          prev_eof = mon_e.eof;
        end
      end else begin
        check("idle_outputs", {sout, sof, eof}, 0);
        prev_eof = 1'b0;
      end
      check("frame_done", frame_done, fd_exp);
      if (frame_done) nfd++;
      model_lvl = acc_cnt - started;
      check("fifo_level", fifo_level, model_lvl);
      check("in_ready", in_ready, model_lvl != int'(DEPTH));
      if (model_lvl == int'(DEPTH)) saw_full = 1'b1;
      if (rst_n && in_valid && (model_lvl != int'(DEPTH))) begin
        acc_cnt++;
        enqueue(in_data);
      end
    end
  end

  // Called #1 after a posedge; the reset edge is the next posedge.
  task automatic do_reset();
    mon_en   = 1'b0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_outputs", {sout, sout_valid, sof, eof, frame_done}, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ready", in_ready, 1);
    rst_n = 1'b1;
    exp_q.delete();
    mw = 0; acc_cnt = 0; started = 0; prev_eof = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic send(input logic [DW-1:0] d);
    bit acc = 1'b0;
    in_data  = d;
    in_valid = 1'b1;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
    end
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int k = 0; k < 3000 && exp_q.size() != 0; k++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check("drain", exp_q.size(), 0);
  endtask

  task automatic table_vec(input vec_t v);
    logic [7:0] gb = '0;
    logic       gp = 1'b0;
    in_data  = v.data;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_early", sout_valid, 0);
    for (int i = 0; i < int'(PER); i++) begin
      @(negedge clk);
      check("lat_valid", sout_valid, 1);
      if (i < int'(DW)) gb[DW-1-i] = sout;
      else gp = sout;
    end
    check("table_bits", gb, v.exp_bits);
    if (PAR != 0) check("table_par", gp, v.exp_par);
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hA5, 8'b1010_0101, 1'b0};
    vecs[1] = '{8'h00, 8'b0000_0000, 1'b0};
    vecs[2] = '{8'hFF, 8'b1111_1111, 1'b0};
    vecs[3] = '{8'h07, 8'b0000_0111, 1'b1};
    vecs[4] = '{8'h3C, 8'b0011_1100, 1'b0};
    vecs[5] = '{8'h80, 8'b1000_0000, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Single words from idle: latency and MSB-first order.
    clear_stats();
    for (int i = 0; i < 6; i++) table_vec(vecs[i]);
    drain();
    check("table_sof_count", nsof, 1);

    // One full frame back-to-back: contiguous bits, one frame_done.
    do_reset();
    clear_stats();
    for (int i = 0; i < 9; i++) send(DW'(i));
    in_valid = 1'b0;
    drain();
    check("frame_bits", nvalid, 9 * PER);
    check("frame_contig", last_v - first_v + 1, 9 * PER);
    check("frame_sof", nsof, 1);
    check("frame_done_cnt", nfd, 1);
    check("frame_full_seen", saw_full, 1);

    // Continuous in_valid with random data: no loss, level bounded.
    do_reset();
    clear_stats();
    for (int i = 0; i < 40; i++) send(DW'($urandom));
    in_valid = 1'b0;
    drain();
    check("stream_bits", nvalid, 40 * PER);
    check("stream_full_seen", saw_full, 1);

    // Underrun mid-frame: frame position retained.
    do_reset();
    clear_stats();
    for (int i = 0; i < 3; i++) send(DW'(8'h11 * (i + 1)));
    in_valid = 1'b0;
    drain();
    repeat (20) @(posedge clk);
    #1;
    for (int i = 3; i < 9; i++) send(DW'(8'h11 * (i + 1)));
    in_valid = 1'b0;
    drain();
    check("underrun_sof", nsof, 1);
    check("underrun_fd", nfd, 1);
    check("underrun_bits", nvalid, 9 * PER);
    check("underrun_gap", (last_v - first_v + 1) > nvalid, 1);

    // Reset during bit 4 of word 5, then the next word must start a new frame.
    clear_stats();
    for (int i = 0; i < 6; i++) send(DW'(8'h20 + i));
    in_valid = 1'b0;
    for (int k = 0; k < 500 && nvalid != int'(5 * PER + 4); k++) begin
      @(posedge clk); #1;
    end
    check("mid_reached", nvalid, 5 * PER + 4);
    do_reset();
    clear_stats();
    send(8'hC3);
    in_valid = 1'b0;
    drain();
    check("post_rst_sof", nsof, 1);
    check("post_rst_bits", nvalid, PER);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
